// File: rtl/icache_refill.sv
// Instruction-cache refill controller: fetches one cacheline word by word from
// memory and hands the assembled line plus a round-robin victim to the cache set.
module icache_refill #(
  parameter int unsigned N_CACHELINE_LENGTH = 4,
  parameter int unsigned N_CACHELINES       = 8,
  parameter int unsigned BITSIZE            = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_i,
  input  logic                                  miss_i,
  input  logic [31:0]                           miss_addr_i,
  input  logic                                  abort_i,
  output logic                                  busy_o,
  output logic                                  mem_req_o,
  output logic [31:0]                           mem_addr_o,
  input  logic                                  mem_ack_i,
  input  logic                                  mem_rvalid_i,
  input  logic [BITSIZE-1:0]                    mem_rdata_i,
  output logic [BITSIZE*N_CACHELINE_LENGTH-1:0] line_o,
  output logic [N_CACHELINES-1:0]               replace_o,
  output logic                                  done_o
);

  localparam int unsigned W_BYTES = BITSIZE / 8;
  localparam int unsigned CNT_W   = $clog2(N_CACHELINE_LENGTH);
  localparam int unsigned VP_W    = (N_CACHELINES > 1) ? $clog2(N_CACHELINES) : 1;
  localparam int unsigned LINE_W  = BITSIZE * N_CACHELINE_LENGTH;
  localparam logic [31:0] OFF_MASK = 32'(N_CACHELINE_LENGTH * W_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CACHELINE_LENGTH - 1);
  localparam logic [VP_W-1:0]  VP_LAST  = VP_W'(N_CACHELINES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        base_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [VP_W-1:0]    vp_q;
  logic [LINE_W-1:0]  line_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; aborts win over progress except in WRITE and DRAIN
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (miss_i && !abort_i) state_d = S_REQ;
      S_REQ: begin
        if (abort_i)        state_d = mem_ack_i ? S_DRAIN : S_IDLE;
        else if (mem_ack_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (abort_i)           state_d = mem_rvalid_i ? S_IDLE : S_DRAIN;
        else if (mem_rvalid_i) state_d = (cnt_q == CNT_LAST) ? S_WRITE : S_REQ;
      end
      S_WRITE: state_d = S_IDLE;
      S_DRAIN: if (mem_rvalid_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Line base, word counter, line buffer and victim pointer
  always_ff @(posedge clk) begin
    if (rst_i) begin
      base_q <= '0;
      cnt_q  <= '0;
      vp_q   <= '0;
      line_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (miss_i && !abort_i) begin
            base_q <= miss_addr_i & ~OFF_MASK;
            cnt_q  <= '0;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i && !abort_i) begin
            for (int i = 0; i < int'(N_CACHELINE_LENGTH); i++) begin
              if (cnt_q == CNT_W'(i)) line_q[i*BITSIZE +: BITSIZE] <= mem_rdata_i;
            end
            if (cnt_q != CNT_LAST) cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WRITE: vp_q <= (vp_q == VP_LAST) ? '0 : vp_q + VP_W'(1);
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only
  always_comb begin
    busy_o     = (state_q != S_IDLE);
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    replace_o  = '0;
    done_o     = 1'b0;
    case (state_q)
      S_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = base_q + 32'(cnt_q) * 32'(W_BYTES);
      end
      S_WRITE: begin
        replace_o = N_CACHELINES'(1) << vp_q;
        done_o    = 1'b1;
      end
      default: ;
    endcase
  end

  assign line_o = line_q;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: a delay-programmable memory responder plus
// hand-computed latencies, victim sequence and line contents.
module tb_icache_refill;

  localparam int unsigned NL = 4;
  localparam int unsigned NC = 8;
  localparam int unsigned BW = 32;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              miss_i;
  logic [31:0]       miss_addr_i;
  logic              abort_i;
  logic              busy_o;
  logic              mem_req_o;
  logic [31:0]       mem_addr_o;
  logic              mem_ack_i;
  logic              mem_rvalid_i;
  logic [BW-1:0]     mem_rdata_i;
  logic [BW*NL-1:0]  line_o;
  logic [NC-1:0]     replace_o;
  logic              done_o;

  always #5 clk = ~clk;

  icache_refill #(
    .N_CACHELINE_LENGTH(NL),
    .N_CACHELINES      (NC),
    .BITSIZE           (BW)
  ) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .miss_i      (miss_i),
    .miss_addr_i (miss_addr_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .line_o      (line_o),
    .replace_o   (replace_o),
    .done_o      (done_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder state, programmed per word index addr[3:2]
  int          ack_dly[4] = '{0, 0, 0, 0};
  int          rv_dly[4]  = '{0, 0, 0, 0};
  int          phase = 0;
  int          ack_wait = 0;
  int          rv_wait = 0;
  int          widx = 0;
  logic [31:0] req_addr;
  logic [31:0] rd_addr;
  logic [7:0]  rid = 8'h00;
  logic [31:0] acked[$];

  function automatic logic [31:0] mdata(input logic [31:0] a, input logic [7:0] id);
    return {a[15:0], 8'hC3, id};
  endfunction

  initial begin
    mem_ack_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      mem_ack_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      if (phase == 0) begin
        if (mem_req_o) begin
          if (ack_wait == 0) req_addr = mem_addr_o;
          else check("req_addr_hold", 128'(mem_addr_o), 128'(req_addr));
          widx = int'(mem_addr_o[3:2]);
          if (ack_wait >= ack_dly[widx]) begin
            mem_ack_i = 1'b1;
            acked.push_back(mem_addr_o);
            rd_addr  = mem_addr_o;
            phase    = 1;
            ack_wait = 0;
            rv_wait  = 0;
          end else begin
            ack_wait++;
          end
        end else begin
          ack_wait = 0;
        end
      end else begin
        if (rv_wait >= rv_dly[widx]) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mdata(rd_addr, rid);
          phase        = 0;
        end else begin
          rv_wait++;
        end
      end
    end
  end

  int exp_vp = 0;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    miss_i  = 1'b0;
    abort_i = 1'b0;
    step();
    step();
    rst_i  = 1'b0;
    exp_vp = 0;
  endtask

  // Issue a miss, find done_o, check latency, victim, line, and one-cycle pulse
  task automatic run_refill(input logic [31:0] addr, input int exp_lat, input string tag);
    logic [31:0]  base;
    logic [127:0] exp_line;
    int lat;
    rid++;
    base = addr & ~32'hF;
    for (int i = 0; i < 4; i++) exp_line[i*32 +: 32] = mdata(base + 32'(4*i), rid);
    miss_i      = 1'b1;
    miss_addr_i = addr;
    step();
    miss_i = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (done_o) begin
        lat = i;
        break;
      end
      step();
    end
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check({tag, "_replace"}, 128'(replace_o), 128'(8'(1) << exp_vp));
    check({tag, "_line"}, line_o, exp_line);
    step();
    check({tag, "_pulse_end"}, 128'({replace_o, done_o}), 128'(0));
    exp_vp = (exp_vp + 1) % NC;
  endtask

  initial begin
    rst_i       = 1'b1;
    miss_i      = 1'b0;
    miss_addr_i = '0;
    abort_i     = 1'b0;
    step();

    // Reset state
    do_reset();
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_req", 128'(mem_req_o), 128'(0));
    check("rst_addr", 128'(mem_addr_o), 128'(0));
    check("rst_replace", 128'({replace_o, done_o}), 128'(0));
    check("rst_line", line_o, 128'(0));

    // Basic refill
    acked.delete();
    run_refill(32'h0000_1234, 9, "basic");
    check("basic_nreq", 128'(acked.size()), 128'(4));
    for (int i = 0; i < 4 && i < acked.size(); i++)
      check($sformatf("basic_addr%0d", i), 128'(acked[i]), 128'(32'h1230 + 32'(4*i)));
    check("basic_idle", 128'(busy_o), 128'(0));

    // Round robin: eight more back-to-back refills wrap the victim pointer
    for (int r = 0; r < 8; r++)
      run_refill(32'h0000_2008 + 32'(r * 'h40), 9, $sformatf("rr%0d", r));

    // Backpressure on acknowledge, then on response
    ack_dly[1] = 3;
    run_refill(32'h0000_1234, 12, "ack_dly");
    ack_dly[1] = 0;
    rv_dly[2] = 2;
    run_refill(32'h0000_1234, 11, "rv_dly");
    rv_dly[2] = 0;

    // Abort in WAIT of word 2 with response two cycles later
    do_reset();
    rv_dly[2]   = 2;
    miss_i      = 1'b1;
    miss_addr_i = 32'h0000_1234;
    step();
    miss_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("wabort_drain1", 128'({busy_o, mem_req_o, replace_o}), 128'({1'b1, 1'b0, 8'h00}));
    step();
    check("wabort_drain2", 128'({busy_o, mem_req_o, replace_o}), 128'({1'b1, 1'b0, 8'h00}));
    step();
    check("wabort_idle", 128'({busy_o, replace_o}), 128'(0));
    rv_dly[2] = 0;
    run_refill(32'h0000_1234, 9, "after_wabort");

    // Abort and acknowledge together in REQ leaves a response owed
    rv_dly[0]   = 2;
    miss_i      = 1'b1;
    miss_addr_i = 32'h0000_3000;
    step();
    miss_i  = 1'b0;
    abort_i = 1'b1;
    check("rabort_req", 128'(mem_req_o), 128'(1));
    step();
    abort_i = 1'b0;
    check("rabort_drain1", 128'({busy_o, mem_req_o}), 128'(2'b10));
    step();
    check("rabort_drain2", 128'({busy_o, replace_o}), 128'({1'b1, 8'h00}));
    step();
    check("rabort_drain3", 128'({busy_o, replace_o}), 128'({1'b1, 8'h00}));
    step();
    check("rabort_idle", 128'({busy_o, replace_o}), 128'(0));
    rv_dly[0] = 0;
    run_refill(32'h0000_3004, 9, "after_rabort");

    // Mid-refill reset with miss held high throughout
    miss_i      = 1'b1;
    miss_addr_i = 32'h0000_1234;
    step();
    step();
    step();
    check("held_miss_w1", 128'({mem_req_o, mem_addr_o}), 128'({1'b1, 32'h1234}));
    step();
    check("held_miss_wait", 128'({busy_o, mem_req_o}), 128'(2'b10));
    step();
    check("held_miss_w2", 128'({mem_req_o, mem_addr_o}), 128'({1'b1, 32'h1238}));
    rst_i = 1'b1;
    step();
    check("mrst_outs", 128'({busy_o, mem_req_o, mem_addr_o, replace_o, done_o}), 128'(0));
    check("mrst_line", line_o, 128'(0));
    rst_i  = 1'b0;
    miss_i = 1'b0;
    exp_vp = 0;
    run_refill(32'h0000_1234, 9, "after_mrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
